// File: rtl/cordic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cordic_pkg: shared CORDIC widths, gain constants, angle table, FSM.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cordic_pkg;

    localparam int C_WORK_W     = 10;
    localparam int C_I_W        = 3;
    localparam int C_GAIN       = 79;
    localparam int C_GAIN_SHIFT = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        SCALE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // atan(2^-i) in Q2.6 radians
    function automatic logic signed [7:0] atan_lut(input logic [C_I_W-1:0] idx);
        logic signed [7:0] val;
        case (idx)
            3'd0:    val = 8'sd50;
            3'd1:    val = 8'sd30;
            3'd2:    val = 8'sd16;
            3'd3:    val = 8'sd8;
            3'd4:    val = 8'sd4;
            3'd5:    val = 8'sd2;
            3'd6:    val = 8'sd1;
            default: val = 8'sd0;
        endcase
        return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_gain_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cordic_gain_sat: sign-magnitude gain correction, saturated to 8 bit. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cordic_gain_sat
    import cordic_pkg::*;
(
    input  logic signed [C_WORK_W-1:0] i_v,
    output logic signed [7:0]          o_v
);

    localparam int PROD_W = C_WORK_W + 7;

    logic [C_WORK_W-1:0] w_mag;
    logic [PROD_W-1:0]   w_prod;
    logic [PROD_W-1:0]   w_scaled;

    // Magnitude is truncated before the sign is restored, so rounding is
    // symmetric about zero rather than toward minus infinity.
    always_comb begin
        w_mag    = i_v[C_WORK_W-1] ? C_WORK_W'(-i_v) : C_WORK_W'(i_v);
        w_prod   = PROD_W'(w_mag) * PROD_W'(C_GAIN);
        w_scaled = w_prod >> C_GAIN_SHIFT;
        if (i_v[C_WORK_W-1]) begin
            if (w_scaled >= PROD_W'(128)) begin
                o_v = -8'sd128;
            end else begin
                o_v = 8'd0 - w_scaled[7:0];
            end
        end else begin
            if (w_scaled > PROD_W'(127)) begin
                o_v = 8'sd127;
            end else begin
                o_v = w_scaled[7:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cordic_seq_ctrl: iterative CORDIC rotator with valid/ready handshake.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cordic_seq_ctrl
    import cordic_pkg::*;
#(
    parameter int N_ITER = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [7:0] x_in,
    input  logic signed [7:0] y_in,
    input  logic signed [7:0] z_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic signed [7:0] x_out,
    output logic signed [7:0] y_out,
    output logic signed [7:0] z_res
);

    localparam logic [C_I_W-1:0] LAST_ITER = C_I_W'(N_ITER - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic signed [C_WORK_W-1:0] r_x;
    logic signed [C_WORK_W-1:0] r_y;
    logic signed [7:0]          r_z;
    logic [C_I_W-1:0]           r_i;
    logic signed [C_WORK_W-1:0] w_x_sh;
    logic signed [C_WORK_W-1:0] w_y_sh;
    logic signed [7:0]          w_x_gain;
    logic signed [7:0]          w_y_gain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ROTATE;
            end
            ROTATE: begin
                if (r_i == LAST_ITER) w_state_nxt = SCALE;
            end
            SCALE: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_x_sh = r_x >>> r_i;
    assign w_y_sh = r_y >>> r_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_i   <= '0;
            x_out <= '0;
            y_out <= '0;
            z_res <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x <= {{(C_WORK_W-8){x_in[7]}}, x_in};
                        r_y <= {{(C_WORK_W-8){y_in[7]}}, y_in};
                        r_z <= z_in;
                        r_i <= '0;
                    end
                end
                ROTATE: begin
                    // Drive the residual angle toward zero: rotate forward
                    // while it is non-negative, backward otherwise.
                    if (!r_z[7]) begin
                        r_x <= r_x - w_y_sh;
                        r_y <= r_y + w_x_sh;
                        r_z <= r_z - atan_lut(r_i);
                    end else begin
                        r_x <= r_x + w_y_sh;
                        r_y <= r_y - w_x_sh;
                        r_z <= r_z + atan_lut(r_i);
                    end
                    r_i <= r_i + 3'd1;
                end
                SCALE: begin
                    x_out <= w_x_gain;
                    y_out <= w_y_gain;
                    z_res <= r_z;
                end
                default: ;
            endcase
        end
    end

    cordic_gain_sat u_gain_x (
        .i_v (r_x),
        .o_v (w_x_gain)
    );

    cordic_gain_sat u_gain_y (
        .i_v (r_y),
        .o_v (w_y_gain)
    );

endmodule
`default_nettype wire

// File: doc/cordic_seq_ctrl.md
CORDIC_SEQ_CTRL -- requirements
Module: cordic_seq_ctrl

Interface
REQ-001 SHALL have parameter N_ITER, default 8, meaning number of CORDIC micro-rotations; legal range 1..8.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, request carries a valid operand set.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand set.
REQ-006 SHALL have ports x_in and y_in, input, 8 each, signed vector components in two's complement.
REQ-007 SHALL have port z_in, input, 8, signed rotation angle in Q2.6 radians (1 LSB = 2^-6 rad); legal range -111..+111.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-010 SHALL have ports x_out and y_out, output, 8 each, signed rotated and gain-corrected vector components.
REQ-011 SHALL have port z_res, output, 8, signed residual angle after the last iteration.

Function
REQ-012 SHALL implement FSM states IDLE, ROTATE, SCALE and DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE.
REQ-014 SHALL, on in_valid && in_ready, sign-extend x_in/y_in into 10-bit working registers, load z_in, clear iteration counter i, and go to ROTATE.
REQ-015 SHALL, in ROTATE on each edge, set d = +1 if z >= 0, else -1, and update x <= x - d*(y>>>i), y <= y + d*(x>>>i), z <= z - d*ATAN[i]; shifts are arithmetic, 10-bit wrap-free.
REQ-016 SHALL increment i each ROTATE edge and go to SCALE after the edge where i = N_ITER-1.
REQ-017 SHALL, in SCALE, register x_out/y_out = saturate_to_[-128,127]( sign(v) * ((|v|*79)>>7) ), truncating the magnitude, and go to DONE with out_valid = 1.
REQ-018 SHALL make latency exactly N_ITER+1 edges from the accepting edge to the edge setting out_valid (9 for N_ITER = 8).
REQ-019 SHALL hold out_valid, x_out, y_out and z_res stable in DONE until out_valid && out_ready.
REQ-020 SHALL, on the completing handshake edge, return to IDLE so that in_ready = 1 in the next cycle; back-to-back accept in the same cycle is not permitted.
REQ-021 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.
REQ-022 SHALL make z_res equal the 8-bit z register after the final iteration.

Reset
REQ-023 SHALL, while rst = 1, force state IDLE, i = 0, working registers 0, x_out = y_out = z_res = 0, out_valid = 0 and in_ready = 1 in the following cycle.
REQ-024 SHALL discard any in-flight operation when reset is asserted in ROTATE, SCALE or DONE, with no out_valid pulse afterwards.

Structure
REQ-025 SHALL place the FSM state enum, the ATAN table {50,30,16,8,4,2,1,0} (Q2.6), the gain constant 79 with its shift 7, and the working width 10 in shared package cordic_pkg.
REQ-026 SHALL put the gain correction and saturation in one combinational sub-module, cordic_gain_sat (10-bit signed in, 8-bit signed out), instantiated twice (x and y).

Verification
REQ-027 SHALL verify a basic rotation: x_in=64, y_in=0, z_in=0 -> out_valid 9 edges after accept, x_out=65, y_out=1, z_res=-1.
REQ-028 SHALL verify the zero vector: x_in=0, y_in=0, z_in=50 -> x_out=0, y_out=0.
REQ-029 SHALL verify saturation: x_in=127, y_in=127, z_in=0 -> x_out and y_out in 120..127 with no negative wrap.
REQ-030 SHALL verify backpressure: out_ready low for 5 cycles after out_valid -> outputs stable, in_ready = 0 throughout; in_ready = 1 the cycle after handshake.
REQ-031 SHALL verify reset mid-operation: rst pulsed at ROTATE i=4 -> in_ready = 1 next cycle, out_valid never asserted for the aborted operation; a new operation then completes correctly.
REQ-032 SHALL verify input ignored when busy: in_valid held high throughout an operation -> exactly one accept per IDLE visit, each result matching a bit-accurate model.
